// File: rtl/wb_sram_bridge.sv
// Single-outstanding pipelined Wishbone slave driving a synchronous SRAM port.
// Define WB_SRAM_BRIDGE_WR_EN to enable writes; otherwise writes are acked but never issued.
module wb_sram_bridge #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_n_i,
  input  logic                                       wb_cyc_i,
  input  logic                                       wb_stb_i,
  input  logic                                       wb_we_i,
  input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0] wb_adr_i,
  input  logic [DATA_WIDTH/8-1:0]                    wb_sel_i,
  input  logic [DATA_WIDTH-1:0]                      wb_dat_i,
  output logic [DATA_WIDTH-1:0]                      wb_dat_o,
  output logic                                       wb_ack_o,
  output logic                                       wb_stall_o,
  output logic                                       wb_err_o,
  output logic                                       wb_rty_o,
  output logic [ADDR_WIDTH-1:0]                      sram_addr_o,
  output logic                                       sram_re_o,
  output logic                                       sram_we_o,
  output logic [DATA_WIDTH/8-1:0]                    sram_be_o,
  output logic [DATA_WIDTH-1:0]                      sram_data_o,
  input  logic [DATA_WIDTH-1:0]                      sram_data_i
);

  localparam int OFS   = $clog2(DATA_WIDTH/8);
  localparam int BW    = DATA_WIDTH/8;
  localparam int CNT_W = $clog2(RD_LATENCY+1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    we_reg;
  logic                    abort_reg;
  logic                    ack_reg;
  logic                    re_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
`ifdef WB_SRAM_BRIDGE_WR_EN
  logic                    wstb_reg;
  logic [BW-1:0]           be_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
`endif

  logic accept;
  logic abort_now;

  assign accept    = wb_cyc_i & wb_stb_i & (state_reg == S_IDLE);
  // Once the master drops cyc the access still runs to completion, only the ack is withheld.
  assign abort_now = abort_reg | ~wb_cyc_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      abort_reg <= 1'b0;
      ack_reg   <= 1'b0;
      re_reg    <= 1'b0;
      addr_reg  <= '0;
      rdata_reg <= '0;
`ifdef WB_SRAM_BRIDGE_WR_EN
      wstb_reg  <= 1'b0;
      be_reg    <= '0;
      wdata_reg <= '0;
`endif
    end else begin
      re_reg  <= 1'b0;
      ack_reg <= 1'b0;
`ifdef WB_SRAM_BRIDGE_WR_EN
      wstb_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_reg <= S_ACCESS;
            addr_reg  <= wb_adr_i[ADDR_WIDTH+OFS-1:OFS];
            we_reg    <= wb_we_i;
            abort_reg <= 1'b0;
            re_reg    <= ~wb_we_i;
`ifdef WB_SRAM_BRIDGE_WR_EN
            wstb_reg  <= wb_we_i;
            be_reg    <= wb_sel_i;
            wdata_reg <= wb_dat_i;
`endif
          end
        end
        S_ACCESS: begin
          if (we_reg) begin
            state_reg <= S_ACK;
            ack_reg   <= ~abort_now;
          end else begin
            state_reg <= S_WAIT;
            cnt_reg   <= CNT_W'(RD_LATENCY);
            abort_reg <= abort_now;
          end
        end
        S_WAIT: begin
          cnt_reg   <= cnt_reg - CNT_W'(1);
          abort_reg <= abort_now;
          if (cnt_reg == CNT_W'(1)) begin
            rdata_reg <= sram_data_i;
            state_reg <= S_ACK;
            ack_reg   <= ~abort_now;
          end
        end
        S_ACK: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_dat_o    = rdata_reg;
  assign wb_ack_o    = ack_reg & wb_cyc_i;
  assign wb_stall_o  = (state_reg != S_IDLE);
  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;
  assign sram_addr_o = addr_reg;
  assign sram_re_o   = re_reg;

`ifdef WB_SRAM_BRIDGE_WR_EN
  assign sram_we_o   = wstb_reg;
  assign sram_be_o   = be_reg;
  assign sram_data_o = wdata_reg;
`else
  logic unused_wr;
  assign unused_wr   = ^{wb_dat_i, wb_sel_i};
  assign sram_we_o   = 1'b0;
  assign sram_be_o   = '0;
  assign sram_data_o = '0;
`endif

  generate
    if (OFS > 0) begin : g_ofs
      logic unused_adr;
      assign unused_adr = ^wb_adr_i[OFS-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: three instances (read latency 1, 2, 4) against a bench SRAM
// and an expected-memory reference model; table vectors, hand sequences and random traffic.
module tb_wb_sram_bridge;
  localparam int N = 3;
`ifdef WB_SRAM_BRIDGE_WR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        cyc [N], stb [N], we [N];
  logic [7:0]  adr [N];
  logic [3:0]  sel [N];
  logic [31:0] dat_w [N], dat_r [N];
  logic        ack [N], stall [N], err [N], rty [N];
  logic [5:0]  s_addr [N];
  logic        s_re [N], s_we [N];
  logic [3:0]  s_be [N];
  logic [31:0] s_dout [N], s_din [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      wb_sram_bridge #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32),
        .RD_LATENCY(gi == 0 ? 1 : (gi == 1 ? 2 : 4))
      ) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wb_cyc_i(cyc[gi]), .wb_stb_i(stb[gi]), .wb_we_i(we[gi]),
        .wb_adr_i(adr[gi]), .wb_sel_i(sel[gi]), .wb_dat_i(dat_w[gi]),
        .wb_dat_o(dat_r[gi]), .wb_ack_o(ack[gi]), .wb_stall_o(stall[gi]),
        .wb_err_o(err[gi]), .wb_rty_o(rty[gi]),
        .sram_addr_o(s_addr[gi]), .sram_re_o(s_re[gi]), .sram_we_o(s_we[gi]),
        .sram_be_o(s_be[gi]), .sram_data_o(s_dout[gi]), .sram_data_i(s_din[gi])
      );
    end
  endgenerate

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] init_val(input int k, input int a);
    if (a == 5) return 32'hDEADBEEF;
    return (32'(k + 1) << 28) ^ (32'(a) * 32'h0001_0203) ^ 32'h0000_5A5A;
  endfunction

  // Bench SRAM: data appears RD_LATENCY cycles after the read strobe, garbage otherwise.
  logic [31:0] sram_mem [N][64];
  logic [31:0] pipe [N][8];
  logic        filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int k = 0; k < N; k++)
        for (int a = 0; a < 64; a++) sram_mem[k][a] <= init_val(k, a);
      filled <= 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (s_we[k])
        for (int b = 0; b < 4; b++)
          if (s_be[k][b]) sram_mem[k][s_addr[k]][8*b +: 8] <= s_dout[k][8*b +: 8];
      pipe[k][0] <= s_re[k] ? sram_mem[k][s_addr[k]] : 32'hBAD0_BAD0;
      for (int j = 1; j < 8; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end
  always_comb begin
    for (int k = 0; k < N; k++) s_din[k] = pipe[k][lat(k)-1];
  end

  // Reference model: expected memory contents per instance.
  logic [31:0] refmem [N][64];
  int n_checks = 0;
  int n_fail   = 0;
  int cur_k    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got %0h, expected %0h", name, cur_k, act, exp);
    end
  endtask

  typedef struct {
    int re_n; int re_cnt; int we_cnt; int ack_n; int ack_cnt; int stall_low_n;
    logic stall0; logic [5:0] addr1; logic [3:0] be1; logic [31:0] dout1;
    logic [31:0] rdata; logic [31:0] dat_before; logic [31:0] dat_after;
  } txn_res_t;

  task automatic run_txn(input int k, input logic w, input logic [7:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int abort_n, output txn_res_t r);
    r.re_n = -1; r.re_cnt = 0; r.we_cnt = 0; r.ack_n = -1; r.ack_cnt = 0; r.stall_low_n = -1;
    r.addr1 = '0; r.be1 = '0; r.dout1 = '0; r.rdata = '0;
    @(negedge clk);
    r.stall0 = stall[k];
    r.dat_before = dat_r[k];
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat_w[k] = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (s_re[k]) begin r.re_cnt++; if (r.re_n < 0) r.re_n = n; end
      if (s_we[k]) r.we_cnt++;
      if (ack[k]) begin r.ack_cnt++; r.ack_n = n; r.rdata = dat_r[k]; end
      if (n == 1) begin
        r.addr1 = s_addr[k]; r.be1 = s_be[k]; r.dout1 = s_dout[k];
        stb[k] = 1'b0; we[k] = ~w; adr[k] = 8'($urandom); sel[k] = 4'($urandom); dat_w[k] = $urandom;
      end
      if (n == abort_n) cyc[k] = 1'b0;
      if (!stall[k]) begin r.stall_low_n = n; break; end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    r.dat_after = dat_r[k];
  endtask

  task automatic check_txn(input int k, input logic w, input logic [7:0] a, input logic [3:0] s,
                           input logic [31:0] d, input int abort_n, input txn_res_t r);
    int L = lat(k);
    logic [5:0] wa = a[7:2];
    bit ab = (abort_n != 0);
    logic [31:0] exp_rd;
    cur_k = k;
    chk("stall_c0", r.stall0, 0);
    chk("addr_c1", r.addr1, wa);
    chk("ack_count", r.ack_cnt, ab ? 0 : 1);
    if (!w) begin
      exp_rd = refmem[k][wa];
      chk("re_count", r.re_cnt, 1);
      chk("re_cycle", r.re_n, 1);
      chk("we_count", r.we_cnt, 0);
      chk("ack_cycle", r.ack_n, ab ? -1 : 2 + L);
      chk("stall_end", r.stall_low_n, 3 + L);
      chk("rd_data_hold", r.dat_after, exp_rd);
      if (!ab) chk("rd_data_ack", r.rdata, exp_rd);
    end else begin
      chk("re_count", r.re_cnt, 0);
      chk("we_count", r.we_cnt, WR_EN ? 1 : 0);
      chk("be_c1", r.be1, WR_EN ? s : 4'h0);
      chk("wdata_c1", r.dout1, WR_EN ? d : 32'h0);
      chk("ack_cycle", r.ack_n, ab ? -1 : 2);
      chk("stall_end", r.stall_low_n, 3);
      chk("wr_keeps_dat_o", r.dat_after, r.dat_before);
      if (WR_EN)
        for (int b = 0; b < 4; b++)
          if (s[b]) refmem[k][wa][8*b +: 8] = d[8*b +: 8];
    end
    $display("txn k=%0d %s adr=%02h sel=%h wdat=%08h abort=%0d ack@%0d rdata=%08h",
             k, w ? "WR" : "RD", a, s, d, abort_n, r.ack_n, w ? r.dat_after : r.rdata);
  endtask

  task automatic do_txn(input int k, input logic w, input logic [7:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int abort_n, output txn_res_t r);
    run_txn(k, w, a, s, d, abort_n, r);
    check_txn(k, w, a, s, d, abort_n, r);
  endtask

  typedef struct {
    int k; logic w; logic [7:0] a; logic [3:0] s; logic [31:0] d; int abort_n;
    logic [31:0] exp_rdata; int exp_ack_n; int exp_addr;
  } vec_t;

  initial begin
    vec_t tbl [8];
    txn_res_t r;
    logic [31:0] v;
    int k, abort_n;
    logic w;

    for (int i = 0; i < N; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = 0; sel[i] = 0; dat_w[i] = 0;
      for (int a = 0; a < 64; a++) refmem[i][a] = init_val(i, a);
    end

    v = init_val(0, 2);
    tbl[0] = '{0, 1'b0, 8'h14, 4'h0, 32'h0, 0, 32'hDEADBEEF, 3, 5};
    tbl[1] = '{2, 1'b0, 8'h14, 4'h0, 32'h0, 0, 32'hDEADBEEF, 6, 5};
    tbl[2] = '{0, 1'b1, 8'h08, 4'b0101, 32'h11223344, 0, 32'h0, 2, 2};
    tbl[3] = '{0, 1'b0, 8'h08, 4'h0, 32'h0, 0,
               WR_EN ? {v[31:24], 8'h22, v[15:8], 8'h44} : v, 3, 2};
    tbl[4] = '{1, 1'b1, 8'h0B, 4'h0, 32'hFFFFFFFF, 0, 32'h0, 2, 2};
    tbl[5] = '{1, 1'b0, 8'h08, 4'h0, 32'h0, 0, init_val(1, 2), 4, 2};
    tbl[6] = '{1, 1'b0, 8'h3C, 4'h0, 32'h0, 2, init_val(1, 15), -1, 15};
    tbl[7] = '{1, 1'b0, 8'hFD, 4'h0, 32'h0, 0, init_val(1, 63), 4, 63};

    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      cur_k = i;
      chk("reset_outputs", {dat_r[i], s_dout[i], s_addr[i], s_be[i], s_re[i], s_we[i],
                            ack[i], stall[i], err[i], rty[i]}, '0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].abort_n, r);
      cur_k = tbl[i].k;
      chk("tbl_addr", r.addr1, tbl[i].exp_addr);
      chk("tbl_ack_cycle", r.ack_n, tbl[i].exp_ack_n);
      if (!tbl[i].w)
        chk("tbl_rdata", (tbl[i].abort_n != 0) ? r.dat_after : r.rdata, tbl[i].exp_rdata);
    end

    // Reset asserted while a latency-4 read sits in WAIT.
    do_txn(2, 1'b0, 8'h14, 4'h0, 32'h0, 0, r);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 8'h20;
    @(negedge clk);
    stb[2] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cur_k = 2;
    chk("reset_mid_wait", {dat_r[2], s_dout[2], s_addr[2], s_be[2], s_re[2], s_we[2],
                           ack[2], stall[2]}, '0);
    cur_k = 0;
    chk("reset_mid_wait_wdata", s_dout[0], 32'h0);
    cyc[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_txn(2, 1'b0, 8'h20, 4'h0, 32'h0, 0, r);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, N - 1);
      w = 1'($urandom_range(0, 1));
      abort_n = 0;
      if ($urandom_range(0, 5) == 0) abort_n = w ? 1 : $urandom_range(1, 1 + lat(k));
      do_txn(k, w, 8'($urandom), 4'($urandom), $urandom, abort_n, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
